// File: rtl/ece571f23_g5_aes_subbytes_seq.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE shared S-boxes, 16/BPC beats from accept to out_valid; result held until out_ready.
// Optional macro AES_SUBBYTES_INV_EN adds inverse S-boxes selected by decrypt latched at accept.

module ece571f23_g5_aes_sbox_fwd (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Byte x of the table lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign dout = FWD_TBL[{~din, 3'b000} +: 8];
endmodule

`ifdef AES_SUBBYTES_INV_EN
module ece571f23_g5_aes_sbox_inv (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign dout = INV_TBL[{~din, 3'b000} +: 8];
endmodule
`endif

module ece571f23_g5_aes_subbytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = 8 * BYTES_PER_CYCLE;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state;
  logic [127:0]  work;
  logic [127:0]  work_nxt;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lane_in;
  logic [LW-1:0] lane_out;

`ifdef AES_SUBBYTES_INV_EN
  logic dec_q;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  // Beat cnt owns bytes cnt*BPC .. cnt*BPC+BPC-1; byte k sits at bits [8*(15-k) +: 8].
  always_comb begin
    lane_in  = '0;
    work_nxt = work;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      lane_in[8*j +: 8] = work[8*(15 - (int'(cnt)*BYTES_PER_CYCLE + j)) +: 8];
      work_nxt[8*(15 - (int'(cnt)*BYTES_PER_CYCLE + j)) +: 8] = lane_out[8*j +: 8];
    end
  end

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    logic [7:0] fwd_b;
    ece571f23_g5_aes_sbox_fwd u_fwd (.din(lane_in[8*j +: 8]), .dout(fwd_b));
`ifdef AES_SUBBYTES_INV_EN
    logic [7:0] inv_b;
    ece571f23_g5_aes_sbox_inv u_inv (.din(lane_in[8*j +: 8]), .dout(inv_b));
    assign lane_out[8*j +: 8] = dec_q ? inv_b : fwd_b;
`else
    assign lane_out[8*j +: 8] = fwd_b;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
`ifdef AES_SUBBYTES_INV_EN
      dec_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= data_in;
            cnt   <= '0;
            state <= BUSY;
`ifdef AES_SUBBYTES_INV_EN
            dec_q <= decrypt;
`endif
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign data_out  = work;

endmodule

// File: tb/tb_ece571f23_g5_aes_subbytes_seq.sv
// Bench for ece571f23_g5_aes_subbytes_seq: three instances (BPC 4, 1, 16) against an arithmetic GF(2^8) S-box model.
module tb_ece571f23_g5_aes_subbytes_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         decrypt   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] data_in   [3];
  logic [127:0] data_out  [3];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL63    = {16{8'h63}};

  ece571f23_g5_aes_subbytes_seq #(.BYTES_PER_CYCLE(4)) u_dut_bpc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .decrypt(decrypt[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0]));
  ece571f23_g5_aes_subbytes_seq #(.BYTES_PER_CYCLE(1)) u_dut_bpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .decrypt(decrypt[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1]));
  ece571f23_g5_aes_subbytes_seq #(.BYTES_PER_CYCLE(16)) u_dut_bpc16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in[2]), .decrypt(decrypt[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2]));

  function automatic int beats(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_arith(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, x);   // x^254 is the field inverse (0 -> 0)
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      fwd_tab[x] = sbox_arith(x[7:0]);
      inv_tab[fwd_tab[x]] = x[7:0];
    end
  endtask

  function automatic logic [127:0] subbytes(input logic [127:0] blk, input logic dec);
    logic [127:0] r = '0;
    logic [7:0]   b;
    for (int k = 0; k < 16; k++) begin
      b = blk[8*(15-k) +: 8];
`ifdef AES_SUBBYTES_INV_EN
      r[8*(15-k) +: 8] = dec ? inv_tab[b] : fwd_tab[b];
`else
      r[8*(15-k) +: 8] = fwd_tab[b];
`endif
    end
    return r;
  endfunction

  // Transaction-level view per instance: idle, waiting m_wait edges, or holding m_res.
  bit           m_idle  [3];
  bit           m_valid [3];
  bit           m_known [3];
  int           m_wait  [3];
  logic [127:0] m_res   [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_idle[i] = 1'b1; m_valid[i] = 1'b0; m_known[i] = 1'b1; m_wait[i] = 0;
      end else if (m_valid[i]) begin
        if (out_ready[i]) begin m_valid[i] = 1'b0; m_idle[i] = 1'b1; end
      end else if (!m_idle[i]) begin
        m_wait[i] = m_wait[i] - 1;
        if (m_wait[i] == 0) m_valid[i] = 1'b1;
      end else if (in_valid[i]) begin
        m_idle[i]  = 1'b0;
        m_known[i] = 1'b0;
        m_wait[i]  = beats(i);
        m_res[i]   = subbytes(data_in[i], decrypt[i]);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i), 128'(in_ready[i]), 128'(m_idle[i]));
      chk($sformatf("busy[%0d]", i), 128'(busy[i]), 128'(!m_idle[i] && !m_valid[i]));
      chk($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(m_valid[i]));
      if (m_valid[i]) chk($sformatf("data_out[%0d]", i), data_out[i], m_res[i]);
      else if (m_known[i]) chk($sformatf("data_out_rst[%0d]", i), data_out[i], '0);
    end
  end

  // ---------------- directed helpers (entered at posedge+1) ----------------
  task automatic run_block(input int i, input logic [127:0] din, input logic dec, output int lat);
    int t = 0;
    while (!in_ready[i] && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("wait_in_ready_timeout", 128'(in_ready[i]), 128'(1));
    in_valid[i] = 1'b1; data_in[i] = din; decrypt[i] = dec;
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    lat = 0;
    while (!out_valid[i] && lat < 64) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
    chk($sformatf("idle_after_handshake[%0d]", i), 128'(in_ready[i]), 128'(1));
    chk($sformatf("valid_drop[%0d]", i), 128'(out_valid[i]), 128'(0));
  endtask

  task automatic rand_drive(input int i, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      in_valid[i]  = 1'($urandom_range(0, 1));
      data_in[i]   = {$urandom, $urandom, $urandom, $urandom};
      decrypt[i]   = 1'($urandom_range(0, 1));
      out_ready[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] r, exp_r;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; decrypt[i] = 1'b0; out_ready[i] = 1'b0; data_in[i] = '0;
    end
    build_tables();

    // Pin the model to FIPS-197 literals.
    chk("pin_sbox_00", 128'(fwd_tab[8'h00]), 128'h63);
    chk("pin_sbox_53", 128'(fwd_tab[8'h53]), 128'hed);
    chk("pin_sbox_ff", 128'(fwd_tab[8'hff]), 128'h16);
    chk("pin_inv_ed", 128'(inv_tab[8'hed]), 128'h53);
    chk("pin_appb", subbytes(APPB_IN, 1'b0), APPB_OUT);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      chk($sformatf("rst_busy[%0d]", i), 128'(busy[i]), 128'(0));
      chk($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
      chk($sformatf("rst_data_out[%0d]", i), data_out[i], '0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 App.B at BPC=4
    run_block(0, APPB_IN, 1'b0, lat);
    chk("appb_latency_bpc4", 128'(lat), 128'(4));
    chk("appb_data_bpc4", data_out[0], APPB_OUT);
    release_out(0);

    // All-zero at BPC=1 and BPC=16
    run_block(1, '0, 1'b0, lat);
    chk("zero_latency_bpc1", 128'(lat), 128'(16));
    chk("zero_data_bpc1", data_out[1], ALL63);
    release_out(1);
    run_block(2, '0, 1'b0, lat);
    chk("zero_latency_bpc16", 128'(lat), 128'(1));
    chk("zero_data_bpc16", data_out[2], ALL63);
    release_out(2);

    // Backpressure: result held for 10 cycles
    r = {$urandom, $urandom, $urandom, $urandom};
    exp_r = subbytes(r, 1'b0);
    run_block(0, r, 1'b0, lat);
    for (int c = 0; c < 10; c++) begin
      chk("bp_data_hold", data_out[0], exp_r);
      chk("bp_valid_hold", 128'(out_valid[0]), 128'(1));
      chk("bp_in_ready_low", 128'(in_ready[0]), 128'(0));
      @(posedge clk); #1;
    end
    release_out(0);

    // Input ignore while busy
    in_valid[0] = 1'b1; data_in[0] = APPB_IN; decrypt[0] = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid[0] && lat < 64) begin
      in_valid[0] = ~in_valid[0]; data_in[0] = '1;
      @(posedge clk); #1; lat++;
    end
    in_valid[0] = 1'b0;
    chk("ignore_latency", 128'(lat), 128'(4));
    chk("ignore_data", data_out[0], APPB_OUT);
    release_out(0);

    // Reset mid-flow after two BUSY cycles
    in_valid[0] = 1'b1; data_in[0] = APPB_IN;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("midrst_busy", 128'(busy[0]), 128'(0));
    chk("midrst_data_out", data_out[0], '0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    run_block(0, '0, 1'b0, lat);
    chk("postrst_latency", 128'(lat), 128'(4));
    chk("postrst_data", data_out[0], ALL63);
    release_out(0);

    // Decrypt select
    run_block(0, APPB_OUT, 1'b1, lat);
`ifdef AES_SUBBYTES_INV_EN
    chk("decrypt_inverse", data_out[0], APPB_IN);
`else
    chk("decrypt_ignored", data_out[0], subbytes(APPB_OUT, 1'b0));
`endif
    release_out(0);

    // Randomized traffic on all three instances, checked every cycle by the compare process
    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
      rand_drive(2, 1500);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
